// File: rtl/rand_roller_pkg.sv
// Shared types, default Galois tap masks and period helper for the rand_roller slowing-dice generator.
package rand_roller_pkg;

    typedef enum logic {S_IDLE, S_ROLL} state_t;

    // Right-shift Galois masks known to give maximal-length sequences
    localparam logic [3:0]  TAPS_4  = 4'h9;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] stage_period(input logic [31:0] base, input logic [31:0] stage);
        return base << stage;
    endfunction

endpackage

// File: rtl/rand_roller_lfsr.sv
// Free-running Galois LFSR; a zero SEED is replaced by 1 so the register never locks up.
module rand_roller_lfsr #(
    parameter int              LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'h0001
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= SEED_EFF;
        else          state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
    end

endmodule

// File: rtl/rand_roller.sv
// Slowing-dice roller: samples a free-running LFSR at a rate that halves each stage, then freezes.
// Optional RAND_ROLLER_HISTORY_EN adds o_prev_out holding the previous roll's frozen value.
module rand_roller
    import rand_roller_pkg::*;
#(
    parameter int                OUT_W        = 4,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED         = 16'h0001,
    parameter int                NUM_STAGES   = 5,
    parameter int                BASE_PERIOD  = 3125000,
    parameter int                STAGE_CYCLES = 10000000
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    output logic [OUT_W-1:0]              o_random_out,
    output logic                          o_busy,
    output logic                          o_done,
`ifdef RAND_ROLLER_HISTORY_EN
    output logic [OUT_W-1:0]              o_prev_out,
`endif
    output logic [$clog2(NUM_STAGES):0]   o_stage
);

    localparam int ST_W   = $clog2(NUM_STAGES) + 1;
    localparam int PC_RAW = $clog2(BASE_PERIOD << (NUM_STAGES - 1));
    localparam int PC_W   = (PC_RAW < 1) ? 1 : PC_RAW;
    localparam int SC_RAW = $clog2(STAGE_CYCLES);
    localparam int SC_W   = (SC_RAW < 1) ? 1 : SC_RAW;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   period_cnt;
    logic [SC_W-1:0]   stage_cnt;
    logic [ST_W-1:0]   stage;
    logic [LFSR_W-1:0] lfsr_state;
    logic [31:0]       period_m1;
    logic              rolling, tick, stage_end, finish, done_q;
    logic              unused_lfsr;

    rand_roller_lfsr #(
        .LFSR_W   (LFSR_W),
        .LFSR_TAPS(LFSR_TAPS),
        .SEED     (SEED)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .state  (lfsr_state)
    );

    // Only the low OUT_W bits are displayed; the rest just feed the sequence.
    assign unused_lfsr = ^lfsr_state;

    assign rolling   = (state_q == S_ROLL);
    assign period_m1 = stage_period(32'(BASE_PERIOD), 32'(stage)) - 32'd1;
    assign tick      = rolling && (32'(period_cnt) == period_m1);
    assign stage_end = (stage_cnt == SC_W'(STAGE_CYCLES - 1));
    assign finish    = rolling && stage_end && (stage == ST_W'(NUM_STAGES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_ROLL;
            S_ROLL:  if (i_start) state_d = S_ROLL;
                     else if (finish) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy  = rolling;
        o_stage = rolling ? stage + ST_W'(1) : '0;
        o_done  = done_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            period_cnt   <= '0;
            stage_cnt    <= '0;
            stage        <= '0;
            o_random_out <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= finish && !i_start;
            // A tick on the restart or completion cycle still lands its update.
            if (tick) o_random_out <= lfsr_state[OUT_W-1:0];
            if (i_start) begin
                period_cnt <= '0;
                stage_cnt  <= '0;
                stage      <= '0;
            end else if (rolling) begin
                if (stage_end) begin
                    period_cnt <= '0;
                    stage_cnt  <= '0;
                    stage      <= finish ? '0 : stage + ST_W'(1);
                end else begin
                    stage_cnt  <= stage_cnt + SC_W'(1);
                    period_cnt <= tick ? '0 : period_cnt + PC_W'(1);
                end
            end
        end
    end

`ifdef RAND_ROLLER_HISTORY_EN
    logic [OUT_W-1:0] final_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            final_q    <= '0;
            o_prev_out <= '0;
        end else if (finish && !i_start) begin
            o_prev_out <= final_q;
            final_q    <= tick ? lfsr_state[OUT_W-1:0] : o_random_out;
        end
    end
`endif

endmodule

// File: tb/tb_rand_roller.sv
// Randomized self-checking bench for rand_roller against a roll-age based reference model.
module tb_rand_roller;

    localparam int BP  = 2;
    localparam int NS  = 3;
    localparam int SCY = 16;
    localparam int DONE_LAT = NS * SCY + 1;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [3:0] o_random_out;
    logic       o_busy, o_done;
    logic [2:0] o_stage;
`ifdef RAND_ROLLER_HISTORY_EN
    logic [3:0] o_prev_out;
`endif

    int checks = 0;
    int errors = 0;

    rand_roller #(
        .OUT_W(4), .LFSR_W(16), .LFSR_TAPS(16'hB400), .SEED(16'h0001),
        .NUM_STAGES(NS), .BASE_PERIOD(BP), .STAGE_CYCLES(SCY)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .o_random_out(o_random_out),
        .o_busy      (o_busy),
        .o_done      (o_done),
`ifdef RAND_ROLLER_HISTORY_EN
        .o_prev_out  (o_prev_out),
`endif
        .o_stage     (o_stage)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a roll is described by its age in cycles; stage and
    // tick instants follow directly from that age with plain arithmetic.
    logic [15:0] m_lfsr;
    bit          m_active, m_done;
    int          m_age;
    logic [3:0]  m_out, m_final, m_prev;
    logic        m_tick, m_fin;
    logic [2:0]  exp_stage;

    assign m_tick    = m_active && ((((m_age % SCY) + 1) % (BP << (m_age / SCY))) == 0);
    assign m_fin     = m_active && (m_age == NS * SCY - 1);
    assign exp_stage = m_active ? 3'(m_age / SCY + 1) : 3'd0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_lfsr <= 16'h0001; m_active <= 1'b0; m_age <= 0; m_done <= 1'b0;
            m_out <= 4'd0; m_final <= 4'd0; m_prev <= 4'd0;
        end else begin
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            if (m_tick) m_out <= m_lfsr[3:0];
            m_done <= m_fin && !i_start;
            if (i_start) begin
                m_active <= 1'b1; m_age <= 0;
            end else if (m_fin) begin
                m_active <= 1'b0;
            end else if (m_active) begin
                m_age <= m_age + 1;
            end
            if (m_fin && !i_start) begin
                m_prev  <= m_final;
                m_final <= m_tick ? m_lfsr[3:0] : m_out;
            end
        end
    end

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({o_random_out, o_busy, o_done, o_stage} !== 9'd0) begin
            errors++;
            $display("FAIL reset out=%h busy=%b done=%b stage=%0d required all 0",
                     o_random_out, o_busy, o_done, o_stage);
        end
    endtask

    task automatic test_full_roll(input string name);
        int done_at = -1;
        int n_done  = 0;
        repeat ($urandom_range(2, 12)) @(negedge i_clk);
        for (int k = 0; k <= DONE_LAT + 10; k++) begin
            @(negedge i_clk);
            checks++;
            if ({o_random_out, o_busy, o_done, o_stage} !== {m_out, m_active, m_done, exp_stage}) begin
                errors++;
                $display("FAIL %s k=%0d got out=%h busy=%b done=%b stage=%0d want out=%h busy=%b done=%b stage=%0d",
                         name, k, o_random_out, o_busy, o_done, o_stage, m_out, m_active, m_done, exp_stage);
            end
            if (o_done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            i_start = (k == 0);
        end
        checks++;
        if (done_at != DONE_LAT || n_done != 1) begin
            errors++;
            $display("FAIL %s_done_time got k=%0d (pulses %0d) want k=%0d (1 pulse)", name, done_at, n_done, DONE_LAT);
        end
    endtask

    task automatic test_restart();
        int r = $urandom_range(5, 45);
        int done_at = -1;
        int n_done  = 0;
        for (int k = 0; k <= r + DONE_LAT + 5; k++) begin
            @(negedge i_clk);
            checks++;
            if ({o_random_out, o_busy, o_done, o_stage} !== {m_out, m_active, m_done, exp_stage}) begin
                errors++;
                $display("FAIL restart k=%0d got out=%h busy=%b done=%b stage=%0d want out=%h busy=%b done=%b stage=%0d",
                         k, o_random_out, o_busy, o_done, o_stage, m_out, m_active, m_done, exp_stage);
            end
            if (k == r + 1) begin
                checks++;
                if (o_stage !== 3'd1) begin
                    errors++;
                    $display("FAIL restart_stage got %0d want 1", o_stage);
                end
            end
            if (o_done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            i_start = (k == 0) || (k == r);
        end
        checks++;
        if (done_at != r + DONE_LAT || n_done != 1) begin
            errors++;
            $display("FAIL restart_done_time got k=%0d (pulses %0d) want k=%0d (1 pulse)", done_at, n_done, r + DONE_LAT);
        end
    endtask

    task automatic test_start_on_completion();
        int last = NS * SCY;
        int n_done = 0;
        for (int k = 0; k <= last + DONE_LAT + 5; k++) begin
            @(negedge i_clk);
            checks++;
            if ({o_random_out, o_busy, o_done, o_stage} !== {m_out, m_active, m_done, exp_stage}) begin
                errors++;
                $display("FAIL start_on_completion k=%0d got out=%h busy=%b done=%b stage=%0d want out=%h busy=%b done=%b stage=%0d",
                         k, o_random_out, o_busy, o_done, o_stage, m_out, m_active, m_done, exp_stage);
            end
            if (k == last + 1) begin
                checks++;
                if ({o_busy, o_done, o_stage} !== {1'b1, 1'b0, 3'd1}) begin
                    errors++;
                    $display("FAIL completion_restart got busy=%b done=%b stage=%0d want busy=1 done=0 stage=1",
                             o_busy, o_done, o_stage);
                end
            end
            if (o_done) n_done++;
            i_start = (k == 0) || (k == last);
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL completion_restart_pulses got %0d want 1", n_done);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            checks++;
            if ({o_random_out, o_busy, o_done, o_stage} !== {m_out, m_active, m_done, exp_stage}) begin
                errors++;
                $display("FAIL pre_reset k=%0d got out=%h stage=%0d want out=%h stage=%0d",
                         k, o_random_out, o_stage, m_out, exp_stage);
            end
            i_start = (k == 0);
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_random_out, o_busy, o_done, o_stage} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset out=%h busy=%b done=%b stage=%0d required all 0",
                     o_random_out, o_busy, o_done, o_stage);
        end
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        test_full_roll("post_reset_roll");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge i_clk);
            checks++;
            if ({o_random_out, o_busy, o_done, o_stage} !== {m_out, m_active, m_done, exp_stage}) begin
                errors++;
                $display("FAIL random k=%0d got out=%h busy=%b done=%b stage=%0d want out=%h busy=%b done=%b stage=%0d",
                         k, o_random_out, o_busy, o_done, o_stage, m_out, m_active, m_done, exp_stage);
            end
            i_start = ($urandom_range(0, 29) == 0);
        end
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (DONE_LAT + 2) @(negedge i_clk);
    endtask

`ifdef RAND_ROLLER_HISTORY_EN
    task automatic test_history();
        logic [3:0] first_final;
        test_full_roll("history_roll1");
        first_final = m_out;
        test_full_roll("history_roll2");
        checks++;
        if (o_prev_out !== first_final || o_prev_out !== m_prev) begin
            errors++;
            $display("FAIL history got %h want %h", o_prev_out, first_final);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_roll("full_roll");
        test_restart();
        test_start_on_completion();
        test_async_reset();
        test_random();
        test_full_roll("back_to_back");
`ifdef RAND_ROLLER_HISTORY_EN
        test_history();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
